// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction and data requests onto one RAM port.
// Data side has priority; each access is bounded by a timeout and faults are sticky.
module memory_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TO_MAX = 15
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, DREQ, IREQ, FAULT} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam int CW = $clog2(TO_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TO_MAX);

   state_t        state, next_state;
   logic [CW-1:0] cnt, next_cnt;
   logic          next_err;
   logic          fault_d, next_fault_d;
   logic          dreq, hit, timeout;

   assign dreq    = dREN | dWEN;
   assign hit     = (ramstate == RAM_ACCESS);
   assign timeout = (cnt == CNT_MAX) || (ramstate == RAM_ERROR);

   // state, timeout counter, sticky error and faulting-side flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         cnt     <= '0;
         err     <= 1'b0;
         fault_d <= 1'b0;
      end else begin
         state   <= next_state;
         cnt     <= next_cnt;
         err     <= next_err;
         fault_d <= next_fault_d;
      end
   end

   // next-state: data first, abort on dropped request, hit, then timeout/error
   always_comb begin
      next_state   = state;
      next_cnt     = cnt;
      next_err     = err;
      next_fault_d = fault_d;
      unique case (state)
         IDLE: begin
            if (dreq) begin
               next_state = DREQ;
               next_cnt   = '0;
            end else if (iREN) begin
               next_state = IREQ;
               next_cnt   = '0;
            end
         end
         DREQ: begin
            if (!dreq) begin
               next_state = IDLE;
            end else begin
               if (dREN && dWEN) next_err = 1'b1;
               if (hit) begin
                  next_state = IDLE;
               end else if (timeout) begin
                  next_state   = FAULT;
                  next_err     = 1'b1;
                  next_fault_d = 1'b1;
               end else if (cnt != CNT_MAX) begin
                  next_cnt = cnt + 1'b1;
               end
            end
         end
         IREQ: begin
            if (!iREN) begin
               next_state = IDLE;
            end else if (hit) begin
               next_state = IDLE;
            end else if (timeout) begin
               next_state   = FAULT;
               next_err     = 1'b1;
               next_fault_d = 1'b0;
            end else if (cnt != CNT_MAX) begin
               next_cnt = cnt + 1'b1;
            end
         end
         FAULT: next_state = IDLE;
      endcase
   end

   // outputs: RAM port and requester handshakes, forced to zero during reset
   always_comb begin
      iwait    = 1'b0;
      iload    = '0;
      dwait    = 1'b0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (nRST) begin
         unique case (state)
            IDLE: begin
               iwait = iREN;
               dwait = dreq;
            end
            DREQ: begin
               iwait = iREN;
               dwait = 1'b1;
               if (dreq) begin
                  ramaddr  = daddr;
                  ramstore = dstore;
                  ramWEN   = dWEN;
                  ramREN   = dREN & ~dWEN;
                  if (hit) begin
                     dwait = 1'b0;
                     dload = (dREN && !dWEN) ? ramload : '0;
                  end
               end
            end
            IREQ: begin
               dwait = dreq;
               iwait = 1'b1;
               if (iREN) begin
                  ramaddr = iaddr;
                  ramREN  = 1'b1;
                  if (hit) begin
                     iwait = 1'b0;
                     iload = ramload;
                  end
               end
            end
            FAULT: begin
               if (fault_d) begin
                  iwait = iREN;
                  dwait = 1'b0;
               end else begin
                  iwait = 1'b0;
                  dwait = dreq;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table plus hand-written
// sequences for timeout, RAM error and asynchronous reset.
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   logic [1:0]  ramstate = 2'd0;
   logic        err;

   localparam logic [1:0] F = 2'd0;
   localparam logic [1:0] B = 2'd1;
   localparam logic [1:0] A = 2'd2;
   localparam logic [1:0] E = 2'd3;

   always #5 CLK = ~CLK;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TO_MAX(15)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .err(err)
   );

   typedef struct {
      string       nm;
      logic        nrst;
      logic        iren;
      logic [31:0] ia;
      logic        dren;
      logic        dwen;
      logic [31:0] da;
      logic [31:0] ds;
      logic [31:0] rl;
      logic [1:0]  rs;
      logic [132:0] exp;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   wire [132:0] act = {iwait, iload, dwait, dload, ramREN, ramWEN,
                       ramaddr, ramstore, err};

   // expected output bundle: iwait iload dwait dload rREN rWEN raddr rstore err
   function automatic logic [132:0] pk(
      logic iw, logic [31:0] il, logic dw, logic [31:0] dl,
      logic rr, logic rw, logic [31:0] ra, logic [31:0] rsd, logic e);
      return {iw, il, dw, dl, rr, rw, ra, rsd, e};
   endfunction

   task automatic cmp(input string nm, input logic [132:0] e);
      n_vec++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, e);
      end
   endtask

   task automatic add(input string nm, input logic nr, input logic ir,
                      input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] ds,
                      input logic [31:0] rl, input logic [1:0] rs,
                      input logic [132:0] e);
      vec_t v;
      v.nm = nm; v.nrst = nr; v.iren = ir; v.ia = ia;
      v.dren = dr; v.dwen = dw; v.da = da; v.ds = ds;
      v.rl = rl; v.rs = rs; v.exp = e;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      nRST = v.nrst; iREN = v.iren; iaddr = v.ia;
      dREN = v.dren; dWEN = v.dwen; daddr = v.da; dstore = v.ds;
      ramload = v.rl; ramstate = v.rs;
   endtask

   task automatic idle_in();
      iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
      daddr = 0; dstore = 0; ramload = 0; ramstate = F;
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      idle_in();
      nRST = 0;
      #1 cmp("reset", pk(0,0,0,0,0,0,0,0,0));
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1;
   endtask

   initial begin
      // reset with requests present: outputs must stay zero
      add("rst",    0,1,32'h40,1,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,0));
      // instruction fetch, two BUSY cycles then ACCESS
      add("i_idle", 1,1,32'h40,0,0,0,0,0,F, pk(1,0,0,0,0,0,0,0,0));
      add("i_bsy1", 1,1,32'h40,0,0,0,0,0,B, pk(1,0,0,0,1,0,32'h40,0,0));
      add("i_bsy2", 1,1,32'h40,0,0,0,0,0,B, pk(1,0,0,0,1,0,32'h40,0,0));
      add("i_hit",  1,1,32'h40,0,0,0,0,32'h8C010004,A,
          pk(0,32'h8C010004,0,0,1,0,32'h40,0,0));
      add("gap1",   1,0,0,0,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,0));
      // simultaneous fetch and write: write first, then fetch
      add("w_idle", 1,1,32'h80,0,1,32'h100,32'hDEADBEEF,0,F,
          pk(1,0,1,0,0,0,0,0,0));
      add("w_bsy",  1,1,32'h80,0,1,32'h100,32'hDEADBEEF,0,B,
          pk(1,0,1,0,0,1,32'h100,32'hDEADBEEF,0));
      add("w_hit",  1,1,32'h80,0,1,32'h100,32'hDEADBEEF,32'h99,A,
          pk(1,0,0,0,0,1,32'h100,32'hDEADBEEF,0));
      add("wi_idle",1,1,32'h80,0,0,0,0,0,F, pk(1,0,0,0,0,0,0,0,0));
      add("wi_bsy", 1,1,32'h80,0,0,0,0,0,B, pk(1,0,0,0,1,0,32'h80,0,0));
      add("wi_hit", 1,1,32'h80,0,0,0,0,32'h11112222,A,
          pk(0,32'h11112222,0,0,1,0,32'h80,0,0));
      add("gap2",   1,0,0,0,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,0));
      // write aborted before ACCESS, then a read
      add("ab_idle",1,0,0,0,1,32'h200,32'hCAFEF00D,0,F,
          pk(0,0,1,0,0,0,0,0,0));
      add("ab_bsy", 1,0,0,0,1,32'h200,32'hCAFEF00D,0,B,
          pk(0,0,1,0,0,1,32'h200,32'hCAFEF00D,0));
      add("ab_drop",1,0,0,0,0,32'h200,32'hCAFEF00D,0,B,
          pk(0,0,1,0,0,0,0,0,0));
      add("r_idle", 1,0,0,1,0,32'h204,0,32'h1234,A, pk(0,0,1,0,0,0,0,0,0));
      add("r_hit",  1,0,0,1,0,32'h204,0,32'h1234,A,
          pk(0,0,0,32'h1234,1,0,32'h204,0,0));
      add("gap3",   1,0,0,0,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,0));
      // read+write together: write wins, err set after the edge
      add("rw_idle",1,0,0,1,1,32'h300,32'h55AA55AA,0,F,
          pk(0,0,1,0,0,0,0,0,0));
      add("rw_hit", 1,0,0,1,1,32'h300,32'h55AA55AA,32'h77,A,
          pk(0,0,0,0,0,1,32'h300,32'h55AA55AA,0));
      add("rw_err", 1,0,0,0,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,1));
      // data request during IREQ does not preempt
      add("np_idle",1,1,32'h44,0,0,0,0,0,F, pk(1,0,0,0,0,0,0,0,1));
      add("np_bsy", 1,1,32'h44,1,0,32'h400,0,0,B,
          pk(1,0,1,0,1,0,32'h44,0,1));
      add("np_ihit",1,1,32'h44,1,0,32'h400,0,32'hAAAA0001,A,
          pk(0,32'hAAAA0001,1,0,1,0,32'h44,0,1));
      add("np_gap", 1,0,0,1,0,32'h400,0,0,F, pk(0,0,1,0,0,0,0,0,1));
      add("np_dhit",1,0,0,1,0,32'h400,0,32'hBBBB0002,A,
          pk(0,0,0,32'hBBBB0002,1,0,32'h400,0,1));
      add("end",    1,0,0,0,0,0,0,0,F, pk(0,0,0,0,0,0,0,0,1));

      foreach (vq[i]) begin
         @(negedge CLK);
         drive(vq[i]);
         #1 cmp(vq[i].nm, vq[i].exp);
         @(posedge CLK);
      end

      // asynchronous reset in the middle of an IREQ
      @(negedge CLK);
      idle_in();
      iREN = 1; iaddr = 32'h60; ramstate = B;
      #1 cmp("ar_idle", pk(1,0,0,0,0,0,0,0,1));
      @(posedge CLK);
      #1 cmp("ar_ireq", pk(1,0,0,0,1,0,32'h60,0,1));
      #2 nRST = 0;
      #1 cmp("ar_async", pk(0,0,0,0,0,0,0,0,0));
      @(negedge CLK);
      nRST = 1;
      #1 cmp("ar_rel", pk(1,0,0,0,0,0,0,0,0));
      @(posedge CLK);
      @(negedge CLK);
      ramstate = A; ramload = 32'h77;
      #1 cmp("ar_hit", pk(0,32'h77,0,0,1,0,32'h60,0,0));
      @(posedge CLK);

      // RAM ERROR during IREQ: fault completes the fetch side only
      @(negedge CLK);
      idle_in();
      iREN = 1; iaddr = 32'h70;
      #1 cmp("er_idle", pk(1,0,0,0,0,0,0,0,0));
      @(posedge CLK);
      @(negedge CLK);
      ramstate = E;
      #1 cmp("er_req", pk(1,0,0,0,1,0,32'h70,0,0));
      @(posedge CLK);
      @(negedge CLK);
      ramstate = F; dREN = 1; daddr = 32'h600;
      #1 cmp("er_fault", pk(0,0,1,0,0,0,0,0,1));
      @(posedge CLK);
      @(negedge CLK);
      idle_in();
      #1 cmp("er_after", pk(0,0,0,0,0,0,0,0,1));
      @(posedge CLK);

      pulse_reset();

      // timeout: 16 DREQ cycles with BUSY, then one FAULT cycle
      @(negedge CLK);
      idle_in();
      dREN = 1; daddr = 32'h500; ramstate = B;
      #1 cmp("to_idle", pk(0,0,1,0,0,0,0,0,0));
      @(posedge CLK);
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         #1 cmp($sformatf("to_wait%0d", k),
                pk(0,0,1,0,1,0,32'h500,0,0));
         @(posedge CLK);
      end
      @(negedge CLK);
      iREN = 1;
      #1 cmp("to_fault", pk(1,0,0,0,0,0,0,0,1));
      @(posedge CLK);
      @(negedge CLK);
      idle_in();
      #1 cmp("to_idle2", pk(0,0,0,0,0,0,0,0,1));
      @(posedge CLK);
      // later good read leaves err set
      @(negedge CLK);
      dREN = 1; daddr = 32'h504;
      #1 cmp("to_r_idle", pk(0,0,1,0,0,0,0,0,1));
      @(posedge CLK);
      @(negedge CLK);
      ramstate = A; ramload = 32'hC0DE;
      #1 cmp("to_r_hit", pk(0,0,0,32'hC0DE,1,0,32'h504,0,1));
      @(posedge CLK);
      @(negedge CLK);
      idle_in();
      #1 cmp("to_sticky", pk(0,0,0,0,0,0,0,0,1));
      @(posedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
